// File: rtl/mem_access_unit.sv
// MEM-stage access unit: byte/half/word loads and stores over a req/ack
// data-memory handshake, with upstream stall and an ack watchdog. Drives
// the MEM/WB register fields.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        validIn,
  input  logic [4:0]  rdIn,
  input  logic [31:0] ResultIn,
  input  logic [31:0] Data2In,
  input  logic [31:0] retAddrIn,
  input  logic        memRdIn,
  input  logic        memWrIn,
  input  logic [1:0]  sizeIn,
  input  logic        unsignedIn,
  input  logic        regWrIn,
  input  logic [1:0]  wbSelIn,
  output logic        stallOut,
  output logic        dmReqOut,
  output logic        dmWeOut,
  output logic [31:0] dmAddrOut,
  output logic [31:0] dmWdataOut,
  output logic [3:0]  dmBeOut,
  input  logic        dmAckIn,
  input  logic [31:0] dmRdataIn,
  output logic [4:0]  rdOut,
  output logic [31:0] WbDataOut,
  output logic        regWrOut,
  output logic        validOut,
  output logic        memErrOut
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wdCnt;
  logic [1:0]       sizeQ;
  logic [1:0]       addrLoQ;
  logic             unsQ;

  logic        memop;
  logic        err;
  logic        timeout;
  logic [31:0] wdataNext;
  logic [3:0]  beNext;
  logic [31:0] wbMux;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // Decode: access classification, alignment errors, watchdog expiry.
  always_comb begin
    memop   = validIn & (memRdIn | memWrIn);
    err     = (memRdIn & memWrIn)
            | (sizeIn == 2'b11)
            | ((sizeIn == 2'b01) & ResultIn[0])
            | ((sizeIn == 2'b10) & (ResultIn[1:0] != 2'b00));
    timeout = (ACK_TIMEOUT != 0) && (wdCnt == WD_LAST);
  end

  // Stall: hold upstream while issuing and while waiting, released on ack or abort.
  always_comb begin
    stallOut = 1'b0;
    if (state == IDLE) stallOut = memop & ~err;
    else               stallOut = ~dmAckIn & ~timeout;
  end

  // Store lane replication and byte enables (no enables on loads).
  always_comb begin
    wdataNext = Data2In;
    beNext    = 4'b1111;
    case (sizeIn)
      2'b00: begin
        wdataNext = {4{Data2In[7:0]}};
        beNext    = 4'b0001 << ResultIn[1:0];
      end
      2'b01: begin
        wdataNext = {2{Data2In[15:0]}};
        beNext    = ResultIn[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdataNext = Data2In;
        beNext    = 4'b1111;
      end
    endcase
    if (!memWrIn) beNext = '0;
  end

  // Write-back source select for non-load results.
  always_comb begin
    case (wbSelIn)
      2'b01:   wbMux = '0;
      2'b10:   wbMux = retAddrIn;
      default: wbMux = ResultIn;
    endcase
  end

  // Load lane extraction and sign/zero extension from latched controls.
  always_comb begin
    case (addrLoQ)
      2'b00:   byteSel = dmRdataIn[7:0];
      2'b01:   byteSel = dmRdataIn[15:8];
      2'b10:   byteSel = dmRdataIn[23:16];
      default: byteSel = dmRdataIn[31:24];
    endcase
    halfSel = addrLoQ[1] ? dmRdataIn[31:16] : dmRdataIn[15:0];
    case (sizeQ)
      2'b00:   loadData = unsQ ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadData = unsQ ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadData = dmRdataIn;
    endcase
  end

  // Control FSM, memory request registers and MEM/WB register fields.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state      <= IDLE;
      wdCnt      <= '0;
      sizeQ      <= '0;
      addrLoQ    <= '0;
      unsQ       <= 1'b0;
      dmReqOut   <= 1'b0;
      dmWeOut    <= 1'b0;
      dmAddrOut  <= '0;
      dmWdataOut <= '0;
      dmBeOut    <= '0;
      rdOut      <= '0;
      WbDataOut  <= '0;
      regWrOut   <= 1'b0;
      validOut   <= 1'b0;
      memErrOut  <= 1'b0;
    end else begin
      memErrOut <= 1'b0;
      case (state)
        IDLE: begin
          rdOut <= rdIn;
          if (memop && err) begin
            validOut  <= 1'b1;
            regWrOut  <= 1'b0;
            memErrOut <= 1'b1;
            WbDataOut <= '0;
          end else if (memop) begin
            state      <= BUSY;
            wdCnt      <= '0;
            dmReqOut   <= 1'b1;
            dmWeOut    <= memWrIn;
            dmAddrOut  <= {ResultIn[31:2], 2'b00};
            dmWdataOut <= wdataNext;
            dmBeOut    <= beNext;
            sizeQ      <= sizeIn;
            unsQ       <= unsignedIn;
            addrLoQ    <= ResultIn[1:0];
            validOut   <= 1'b0;
            regWrOut   <= 1'b0;
            WbDataOut  <= '0;
          end else begin
            validOut  <= validIn;
            regWrOut  <= regWrIn & validIn;
            WbDataOut <= wbMux;
          end
        end
        BUSY: begin
          // Upstream is stalled, so rdIn/regWrIn/wbSelIn still describe the held access.
          if (dmAckIn) begin
            state     <= IDLE;
            dmReqOut  <= 1'b0;
            validOut  <= 1'b1;
            rdOut     <= rdIn;
            regWrOut  <= regWrIn;
            WbDataOut <= dmWeOut ? wbMux : loadData;
          end else if (timeout) begin
            state     <= IDLE;
            dmReqOut  <= 1'b0;
            validOut  <= 1'b1;
            rdOut     <= rdIn;
            regWrOut  <= 1'b0;
            memErrOut <= 1'b1;
            WbDataOut <= '0;
          end else begin
            wdCnt    <= wdCnt + 1'b1;
            validOut <= 1'b0;
            regWrOut <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle vectors plus
// hand-written multi-cycle access, timeout and reset sequences.
module tb_mem_access_unit;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic        validIn;
  logic [4:0]  rdIn;
  logic [31:0] ResultIn, Data2In, retAddrIn;
  logic        memRdIn, memWrIn;
  logic [1:0]  sizeIn;
  logic        unsignedIn, regWrIn;
  logic [1:0]  wbSelIn;
  logic        stallOut, dmReqOut, dmWeOut;
  logic [31:0] dmAddrOut, dmWdataOut;
  logic [3:0]  dmBeOut;
  logic        dmAckIn;
  logic [31:0] dmRdataIn;
  logic [4:0]  rdOut;
  logic [31:0] WbDataOut;
  logic        regWrOut, validOut, memErrOut;

  int passCnt = 0;
  int totalCnt = 0;

  mem_access_unit #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .validIn(validIn), .rdIn(rdIn),
    .ResultIn(ResultIn), .Data2In(Data2In), .retAddrIn(retAddrIn),
    .memRdIn(memRdIn), .memWrIn(memWrIn), .sizeIn(sizeIn),
    .unsignedIn(unsignedIn), .regWrIn(regWrIn), .wbSelIn(wbSelIn),
    .stallOut(stallOut), .dmReqOut(dmReqOut), .dmWeOut(dmWeOut),
    .dmAddrOut(dmAddrOut), .dmWdataOut(dmWdataOut), .dmBeOut(dmBeOut),
    .dmAckIn(dmAckIn), .dmRdataIn(dmRdataIn), .rdOut(rdOut),
    .WbDataOut(WbDataOut), .regWrOut(regWrOut), .validOut(validOut),
    .memErrOut(memErrOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] retAddr;
    logic        memRd;
    logic        memWr;
    logic [1:0]  size;
    logic [1:0]  wbSel;
    logic        regWr;
    logic        eValid;
    logic [31:0] eWb;
    logic        eRegWr;
    logic        eErr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else passCnt++;
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic setNop();
    validIn = 1'b0; rdIn = '0; ResultIn = '0; Data2In = '0; retAddrIn = '0;
    memRdIn = 1'b0; memWrIn = 1'b0; sizeIn = 2'b10; unsignedIn = 1'b0;
    regWrIn = 1'b0; wbSelIn = 2'b00;
  endtask

  task automatic driveMem(input logic [4:0] rd, input logic ld, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] d2,
                          input logic [1:0] wbs, input logic rw);
    validIn = 1'b1; rdIn = rd; ResultIn = addr; Data2In = d2; retAddrIn = 32'h0000_0F00;
    memRdIn = ld; memWrIn = ~ld; sizeIn = sz; unsignedIn = uns; regWrIn = rw; wbSelIn = wbs;
  endtask

  // One complete access: issue, ackAfter BUSY cycles without ack, then ack.
  task automatic memAccess(input string nm, input logic [4:0] rd, input logic ld,
                           input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [31:0] d2, input logic [1:0] wbs, input logic rw,
                           input int ackAfter, input logic [31:0] rdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input logic [31:0] expWb);
    int stalls;
    logic hold;
    stalls = 0;
    hold = 1'b1;
    driveMem(rd, ld, sz, uns, addr, d2, wbs, rw);
    #1;
    if (stallOut) stalls++;
    tick();
    chk({nm, " req"}, dmReqOut, 1);
    chk({nm, " addr"}, dmAddrOut, expAddr);
    chk({nm, " we"}, dmWeOut, !ld);
    chk({nm, " be"}, dmBeOut, expBe);
    if (!ld) chk({nm, " wdata"}, dmWdataOut, expWdata);
    chk({nm, " bubble"}, validOut, 0);
    for (int i = 0; i < ackAfter; i++) begin
      if (stallOut) stalls++;
      hold = hold & dmReqOut & (dmAddrOut == expAddr) & (dmBeOut == expBe);
      tick();
    end
    dmAckIn = 1'b1;
    dmRdataIn = rdata;
    #1;
    chk({nm, " ackStall"}, stallOut, 0);
    tick();
    dmAckIn = 1'b0;
    dmRdataIn = '0;
    chk({nm, " stallCycles"}, stalls, ackAfter + 1);
    chk({nm, " held"}, hold, 1);
    chk({nm, " reqDrop"}, dmReqOut, 0);
    chk({nm, " valid"}, validOut, 1);
    chk({nm, " rd"}, rdOut, rd);
    chk({nm, " wb"}, WbDataOut, expWb);
    chk({nm, " regWr"}, regWrOut, rw);
    chk({nm, " err"}, memErrOut, 0);
    setNop();
  endtask

  initial begin
    //            v  rd  result        retAddr       mr mw size   wb     rw  eV eWb           eRw eErr
    vecs[0]  = '{1, 5, 32'h1234,     32'h0,        0, 0, 2'b10, 2'b00, 1,  1, 32'h1234,     1, 0};
    vecs[1]  = '{1, 1, 32'h99,       32'h44,       0, 0, 2'b10, 2'b10, 1,  1, 32'h44,       1, 0};
    vecs[2]  = '{1, 2, 32'h55,       32'h0,        0, 0, 2'b10, 2'b01, 1,  1, 32'h0,        1, 0};
    vecs[3]  = '{1, 3, 32'h77,       32'h10,       0, 0, 2'b10, 2'b11, 0,  1, 32'h77,       0, 0};
    vecs[4]  = '{0, 4, 32'h88,       32'h0,        1, 0, 2'b10, 2'b00, 1,  0, 32'h88,       0, 0};
    vecs[5]  = '{1, 6, 32'h101,      32'h0,        1, 0, 2'b10, 2'b01, 1,  1, 32'h0,        0, 1};
    vecs[6]  = '{1, 7, 32'h100,      32'h0,        1, 0, 2'b11, 2'b01, 1,  1, 32'h0,        0, 1};
    vecs[7]  = '{1, 9, 32'h10,       32'h0,        0, 0, 2'b10, 2'b00, 1,  1, 32'h10,       1, 0};
    vecs[8]  = '{1, 10, 32'h101,     32'h0,        1, 0, 2'b01, 2'b01, 1,  1, 32'h0,        0, 1};
    vecs[9]  = '{1, 11, 32'h100,     32'h0,        1, 1, 2'b00, 2'b01, 1,  1, 32'h0,        0, 1};
    vecs[10] = '{1, 12, 32'h102,     32'h0,        0, 1, 2'b10, 2'b00, 0,  1, 32'h0,        0, 1};
    vecs[11] = '{0, 13, 32'h3,       32'h0,        0, 1, 2'b11, 2'b00, 1,  0, 32'h3,        0, 0};

    resetIn = 1'b1; dmAckIn = 1'b0; dmRdataIn = '0;
    setNop();
    tick(); tick();
    chk("rst req", dmReqOut, 0);
    chk("rst valid", validOut, 0);
    chk("rst wb", WbDataOut, 0);
    chk("rst addrBe", {dmAddrOut[27:0], dmBeOut}, 0);
    chk("rst misc", {dmWeOut, rdOut, regWrOut, memErrOut}, 0);
    resetIn = 1'b0;

    // Single-cycle pass-through and error vectors.
    foreach (vecs[k]) begin
      validIn = vecs[k].valid; rdIn = vecs[k].rd; ResultIn = vecs[k].result;
      retAddrIn = vecs[k].retAddr; memRdIn = vecs[k].memRd; memWrIn = vecs[k].memWr;
      sizeIn = vecs[k].size; wbSelIn = vecs[k].wbSel; regWrIn = vecs[k].regWr;
      Data2In = 32'hFFFF_FFFF; unsignedIn = 1'b0;
      #1;
      chk($sformatf("v%0d stall", k), stallOut, 0);
      tick();
      chk($sformatf("v%0d req", k), dmReqOut, 0);
      chk($sformatf("v%0d valid", k), validOut, vecs[k].eValid);
      chk($sformatf("v%0d rd", k), rdOut, vecs[k].rd);
      chk($sformatf("v%0d wb", k), WbDataOut, vecs[k].eWb);
      chk($sformatf("v%0d regWr", k), regWrOut, vecs[k].eRegWr);
      chk($sformatf("v%0d err", k), memErrOut, vecs[k].eErr);
    end
    setNop();
    tick();
    chk("errOneCycle", memErrOut, 0);

    // Loads and stores; ack after 3 idle BUSY cycles coincides with the watchdog limit.
    memAccess("lb",  7, 1, 2'b00, 0, 32'h103, 32'h0,        2'b01, 1, 3, 32'h80FF_FFFF, 32'h100, 4'b0000, 32'h0,        32'hFFFF_FF80);
    memAccess("lbu", 7, 1, 2'b00, 1, 32'h103, 32'h0,        2'b01, 1, 3, 32'h80FF_FFFF, 32'h100, 4'b0000, 32'h0,        32'h0000_0080);
    memAccess("sh",  8, 0, 2'b01, 0, 32'h202, 32'hDEADBEEF, 2'b00, 0, 0, 32'h0,         32'h200, 4'b1100, 32'hBEEFBEEF, 32'h202);
    memAccess("sb",  9, 0, 2'b00, 0, 32'h301, 32'h123456AB, 2'b00, 0, 1, 32'h0,         32'h300, 4'b0010, 32'hABABABAB, 32'h301);
    memAccess("lh",  3, 1, 2'b01, 0, 32'h106, 32'h0,        2'b01, 1, 0, 32'h8001_7FFF, 32'h104, 4'b0000, 32'h0,        32'hFFFF_8001);
    memAccess("lhu", 3, 1, 2'b01, 1, 32'h106, 32'h0,        2'b01, 1, 1, 32'h8001_7FFF, 32'h104, 4'b0000, 32'h0,        32'h0000_8001);
    memAccess("lhLo",4, 1, 2'b01, 0, 32'h104, 32'h0,        2'b01, 1, 0, 32'h8001_7FFF, 32'h104, 4'b0000, 32'h0,        32'h0000_7FFF);
    memAccess("sw",  5, 0, 2'b10, 0, 32'h400, 32'hCAFEF00D, 2'b00, 0, 2, 32'h0,         32'h400, 4'b1111, 32'hCAFEF00D, 32'h400);
    memAccess("lw",  6, 1, 2'b10, 0, 32'h010, 32'h0,        2'b01, 1, 2, 32'h1122_3344, 32'h010, 4'b0000, 32'h0,        32'h1122_3344);

    // Watchdog abort: no ack, request held for exactly 4 cycles.
    driveMem(14, 1, 2'b10, 0, 32'h20, 32'h0, 2'b01, 1);
    #1;
    chk("to issueStall", stallOut, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to req%0d", i), dmReqOut, 1);
      chk($sformatf("to stall%0d", i), stallOut, (i != 3));
      tick();
    end
    setNop();
    chk("to reqDrop", dmReqOut, 0);
    chk("to valid", validOut, 1);
    chk("to rd", rdOut, 14);
    chk("to regWr", regWrOut, 0);
    chk("to err", memErrOut, 1);
    chk("to wb", WbDataOut, 0);
    dmAckIn = 1'b1; dmRdataIn = 32'hFFFF_FFFF;
    #1;
    chk("stray stall", stallOut, 0);
    tick();
    dmAckIn = 1'b0; dmRdataIn = '0;
    chk("stray req", dmReqOut, 0);
    chk("stray valid", validOut, 0);
    chk("stray err", memErrOut, 0);

    // Reset in the middle of BUSY, then a normal access.
    driveMem(15, 1, 2'b10, 0, 32'h40, 32'h0, 2'b01, 1);
    tick(); tick();
    chk("midrst busy", dmReqOut, 1);
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    setNop();
    chk("midrst req", dmReqOut, 0);
    chk("midrst addr", dmAddrOut, 0);
    chk("midrst valid", {validOut, regWrOut, memErrOut, rdOut}, 0);
    #1;
    chk("midrst stall", stallOut, 0);
    memAccess("postRst", 2, 1, 2'b00, 1, 32'h042, 32'h0, 2'b01, 1, 1, 32'h00C3_0000, 32'h040, 4'b0000, 32'h0, 32'h0000_00C3);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. Performs byte/half/word loads and stores to data memory over a req/ack handshake. Stalls the upstream pipeline while an access is outstanding. Drives the MEM/WB register fields: destination register, write-back data and write enable.

Parameters:
ACK_TIMEOUT, 255, max BUSY cycles waiting for dmAckIn before abort; 0 disables watchdog
CNT_W, 8, watchdog counter width; must hold ACK_TIMEOUT

Ports:
clkIn  input  1  clock, all state updates on rising edge
resetIn  input  1  synchronous reset, active-high
validIn  input  1  EX/MEM slot holds a live instruction
rdIn  input  5  destination register
ResultIn  input  32  ALU result: memory byte address or write-back value
Data2In  input  32  store data (rs2)
retAddrIn  input  32  PC+4 for jal/jalr write-back
memRdIn  input  1  load
memWrIn  input  1  store
sizeIn  input  2  00 byte, 01 half, 10 word, 11 reserved
unsignedIn  input  1  zero-extend load (lbu/lhu)
regWrIn  input  1  instruction writes rd
wbSelIn  input  2  00 ResultIn, 01 load data, 10 retAddrIn, 11 reserved (acts as 00)
stallOut  output  1  hold EX/MEM and earlier stages this cycle
dmReqOut  output  1  memory request, registered
dmWeOut  output  1  1 store, 0 load
dmAddrOut  output  32  word address {ResultIn[31:2],2'b00}
dmWdataOut  output  32  lane-replicated store data
dmBeOut  output  4  byte enables (stores only; 0000 on loads)
dmAckIn  input  1  memory completes request this cycle; dmRdataIn valid
dmRdataIn  input  32  load word
rdOut  output  5  MEM/WB rd
WbDataOut  output  32  MEM/WB write-back data
regWrOut  output  1  MEM/WB register write enable
validOut  output  1  MEM/WB slot live
memErrOut  output  1  one-cycle error flag with the faulting slot

Behaviour:
- Reset (resetIn=1 at edge): state IDLE; watchdog 0. dmReqOut, dmWeOut, dmAddrOut, dmWdataOut, dmBeOut, rdOut, WbDataOut, regWrOut, validOut, memErrOut all 0.
- Reset wins over every event, including mid-BUSY. A late dmAckIn arriving in IDLE is ignored.
- memop = validIn & (memRdIn | memWrIn).
- err is set on any of: memRdIn & memWrIn; sizeIn=11; half access with ResultIn[0]=1; word access with ResultIn[1:0]!=00.
- States: IDLE, BUSY.
- IDLE, !memop: one-cycle pass-through into MEM/WB regs. validOut=validIn; rdOut=rdIn; regWrOut=regWrIn&validIn. WbDataOut per wbSelIn (wbSel 01 gives 0).
- IDLE, memop & err: no request; state stays IDLE. Next edge: validOut=1, regWrOut=0, memErrOut=1, WbDataOut=0.
- IDLE, memop & !err: stallOut=1 (combinational). Next edge: state BUSY, dmReqOut=1. dmWeOut, dmAddrOut, dmWdataOut, dmBeOut and the formatting controls are latched. MEM/WB regs load a bubble: validOut=0, regWrOut=0.
- BUSY: dmReqOut and all dm* outputs held stable until the ack cycle. stallOut = !dmAckIn.
- BUSY & dmAckIn: next edge state IDLE, dmReqOut=0. MEM/WB regs get the instruction: validOut=1, rdOut, regWrOut=regWrIn. WbDataOut = formatted load data for loads, per wbSelIn for stores. memErrOut=0.
- Upstream advances on the same edge, so the held instruction is never reissued.
- Minimum load/store latency is 2 cycles (issue + ack); back-to-back accesses give a 1-cycle bubble between requests.
- Store lanes:
  - byte: wdata={4{Data2In[7:0]}}, be=0001<<ResultIn[1:0].
  - half: wdata={2{Data2In[15:0]}}, be=ResultIn[1]?1100:0011.
  - word: wdata=Data2In, be=1111.
- Load extract: select the byte/half using the latched address bits, then sign-extend, or zero-extend if unsignedIn.
- Watchdog: counter counts BUSY cycles and clears on entering BUSY. If ACK_TIMEOUT!=0 and count reaches ACK_TIMEOUT-1 with no ack:
  - next edge: state IDLE, dmReqOut=0, stallOut=0 in that cycle;
  - MEM/WB: validOut=1, regWrOut=0, memErrOut=1.
- Ack and timeout in the same cycle: ack wins.
- memErrOut lasts exactly one cycle per faulting instruction.
- validIn=0 with memRdIn/memWrIn set: no request, no error.

Test Plan:
- Pass-through: add x5, ResultIn=0x1234, wbSel=00, regWr=1 -> next cycle rdOut=5, WbDataOut=0x1234, regWrOut=1, stallOut never 1.
- lb unsigned=0, ResultIn=0x103, memory ack after 3 BUSY cycles with rdata=0x80FFFFFF -> dmAddrOut=0x100, stallOut=1 for 4 cycles, WbDataOut=0xFFFFFF80; repeat with lbu -> 0x00000080.
- sh ResultIn=0x202, Data2In=0xDEADBEEF -> dmWeOut=1, dmBeOut=1100, dmWdataOut=0xBEEFBEEF, regWrOut=0 after ack.
- lw ResultIn=0x101 -> no dmReqOut, memErrOut=1 for 1 cycle, regWrOut=0; sizeIn=11 gives the same result.
- ACK_TIMEOUT=4, load with no ack -> dmReqOut high 4 cycles then drops, memErrOut=1, stallOut released; a stray dmAckIn afterwards has no effect.
- resetIn asserted during BUSY -> next cycle all outputs 0, state IDLE; next pipeline instruction then processed normally.
